// File: rtl/obstacle_scroller_pkg.sv
// Shared definitions for the HEROE obstacle playfield: FSM states, default
// field geometry, LFSR feedback taps and the 4-bit to 0..9 type fold.
package obstacle_scroller_pkg;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Feedback from bits 7,5,4,3 (x^8 + x^6 + x^5 + x^4 + 1, maximal length)
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] fold_type(input logic [3:0] n);
        return (n < 4'd10) ? n : n - 4'd6;
    endfunction

endpackage

// File: rtl/obstacle_scroller_lfsr.sv
// Obstacle type generator: 8-bit Fibonacci LFSR whose low nibble is folded
// into an obstacle type 0..9 and held in a register between steps.
module obs_lfsr
    import obstacle_scroller_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_i,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    output logic [3:0] tipo_o
);

    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] tipo_q, tipo_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
        // Type register tracks the LFSR value it will hold after this edge
        tipo_d = fold_type(lfsr_d[3:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
            tipo_q <= fold_type(SEED[3:0]);
        end else begin
            lfsr_q <= lfsr_d;
            tipo_q <= tipo_d;
        end
    end

    assign tipo_o = tipo_q;

endmodule

// File: rtl/obstacle_scroller.sv
// HEROE obstacle playfield: game FSM, scrolling field shift register, gap
// counter between obstacle rows, bottom-row collision check and score.
module obstacle_scroller
    import obstacle_scroller_pkg::*;
#(
    parameter int         ROWS = ROWS_DEF,
    parameter int         COLS = COLS_DEF,
    parameter int         GAP  = 2,
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tick,
    input  logic [2:0]           player_col,
    input  logic [COLS-1:0]      obstaculo,
    output logic [3:0]           tipo_obs,
    output logic [ROWS*COLS-1:0] field,
    output logic [15:0]          score,
    output logic                 running,
    output logic                 game_over
);

    localparam logic [3:0] COLS_L = 4'(COLS);
    localparam logic [3:0] GAP_L  = 4'(GAP);

    state_e                 state_q, state_d;
    logic [ROWS*COLS-1:0]   field_q, field_d;
    logic [15:0]            score_q, score_d;
    logic [3:0]             gap_q, gap_d;
    logic [COLS-1:0]        bottom_row, player_mask, row0;
    logic                   coll, lfsr_step, lfsr_load;

    assign bottom_row  = field_q[(ROWS-1)*COLS +: COLS];
    assign player_mask = {{(COLS-1){1'b0}}, 1'b1} << player_col;
    assign coll        = ({1'b0, player_col} < COLS_L) && |(bottom_row & player_mask);

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        score_d   = score_q;
        gap_d     = gap_q;
        row0      = '0;
        lfsr_step = 1'b0;
        lfsr_load = 1'b0;

        if (start) begin
            state_d   = ST_RUN;
            field_d   = '0;
            score_d   = '0;
            gap_d     = '0;
            lfsr_load = 1'b1;
        end else if (state_q == ST_RUN) begin
            // A pending hit freezes the field on the edge that enters OVER
            if (coll) begin
                state_d = ST_OVER;
            end else if (tick) begin
                if (gap_q == 4'd0) begin
                    row0      = obstaculo;
                    gap_d     = GAP_L;
                    lfsr_step = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
                field_d = {field_q[(ROWS-1)*COLS-1:0], row0};
                if (|bottom_row && score_q != 16'hFFFF) begin
                    score_d = score_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            field_q <= '0;
            score_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            score_q <= score_d;
            gap_q   <= gap_d;
        end
    end

    obs_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step_i(lfsr_step),
        .load_i(lfsr_load),
        .seed_i(SEED),
        .tipo_o(tipo_obs)
    );

    assign field     = field_q;
    assign score     = score_q;
    assign running   = (state_q == ST_RUN);
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench for obstacle_scroller: a row-array game model predicts the
// outputs after every clock; a monitor pops and compares after each edge.
module tb_obstacle_scroller;

    localparam int         ROWS = 8;
    localparam int         COLS = 7;
    localparam int         GAP  = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 tick = 1'b0;
    logic [2:0]           player_col = 3'd7;
    logic [COLS-1:0]      obstaculo;
    logic [3:0]           tipo_obs;
    logic [ROWS*COLS-1:0] field;
    logic [15:0]          score;
    logic                 running;
    logic                 game_over;

    always #5 clk = ~clk;

    // Stand-in obstacle ROM; types 1 and 7 are empty rows
    function automatic logic [6:0] rom(input logic [3:0] t);
        case (t)
            4'd0: return 7'b1000001;
            4'd1: return 7'b0000000;
            4'd2: return 7'b0011100;
            4'd3: return 7'b1111111;
            4'd4: return 7'b0100010;
            4'd5: return 7'b0000011;
            4'd6: return 7'b1010101;
            4'd7: return 7'b0000000;
            4'd8: return 7'b0001000;
            4'd9: return 7'b1100000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign obstaculo = rom(tipo_obs);

    obstacle_scroller #(
        .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
        .player_col(player_col), .obstaculo(obstaculo), .tipo_obs(tipo_obs),
        .field(field), .score(score), .running(running), .game_over(game_over)
    );

    typedef struct packed {
        logic [ROWS*COLS-1:0] field;
        logic [15:0]          score;
        logic [3:0]           tipo;
        logic                 running;
        logic                 over;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: rows as an array, mode 0=idle 1=playing 2=over
    logic [6:0] m_rows[ROWS];
    int         m_score;
    int         m_mode;
    int         m_gap;
    logic [7:0] m_lfsr;

    function automatic logic [3:0] m_tipo();
        int v;
        v = int'(m_lfsr[3:0]);
        return (v < 10) ? 4'(v) : 4'(v - 6);
    endfunction

    task automatic m_reset();
        for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
        m_score = 0;
        m_mode  = 0;
        m_gap   = 0;
        m_lfsr  = SEED;
    endtask

    task automatic m_step(input logic st, input logic tk, input int pc);
        logic [6:0] out_row;
        if (st) begin
            m_reset();
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (pc < COLS && m_rows[ROWS-1][pc] == 1'b1) begin
                m_mode = 2;
            end else if (tk) begin
                out_row = m_rows[ROWS-1];
                for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
                if (out_row != 0 && m_score < 65535) m_score++;
                if (m_gap == 0) begin
                    m_rows[0] = rom(m_tipo());
                    m_gap     = GAP;
                    m_lfsr    = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                end else begin
                    m_rows[0] = '0;
                    m_gap--;
                end
            end
        end
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        for (int r = 0; r < ROWS; r++) e.field[r*COLS +: COLS] = m_rows[r];
        e.score   = 16'(m_score);
        e.tipo    = m_tipo();
        e.running = (m_mode == 1);
        e.over    = (m_mode == 2);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("field", 64'(field), 64'(e.field));
            chk("score", 64'(score), 64'(e.score));
            chk("tipo_obs", 64'(tipo_obs), 64'(e.tipo));
            chk("running", 64'(running), 64'(e.running));
            chk("game_over", 64'(game_over), 64'(e.over));
            chk("tipo_range", 64'(tipo_obs <= 4'd9), 64'd1);
        end
    end

    // One clock of stimulus; inputs change on the falling edge
    task automatic cyc(input logic r, input logic st, input logic tk, input logic [2:0] pc);
        @(negedge clk);
        rst_n      = r;
        start      = st;
        tick       = tk;
        player_col = pc;
        if (!r) begin
            m_reset();
            #1;
            chk("rst_field", 64'(field), 64'd0);
            chk("rst_score", 64'(score), 64'd0);
            chk("rst_tipo", 64'(tipo_obs), 64'(m_tipo()));
            chk("rst_running", 64'(running), 64'd0);
            chk("rst_game_over", 64'(game_over), 64'd0);
        end else begin
            m_step(st, tk, int'(pc));
        end
        q.push_back(m_expect());
    endtask

    task automatic spaced_ticks(input int n, input int idle, input logic [2:0] pc);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b1, pc);
            for (int k = 0; k < idle; k++) cyc(1'b1, 1'b0, 1'b0, pc);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        m_reset();
        cyc(1'b0, 1'b0, 1'b0, 3'd7);
        chk("reset_tipo_is_5", 64'(tipo_obs), 64'd5);
        cyc(1'b0, 1'b0, 1'b1, 3'd7);
        cyc(1'b1, 1'b0, 1'b1, 3'd7);

        // Basic scroll, no collision in column 3
        cyc(1'b1, 1'b1, 1'b0, 3'd3);
        spaced_ticks(9, 1, 3'd3);

        // Column 0 collides with the first row; later ticks ignored
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        spaced_ticks(12, 2, 3'd0);

        // Back-to-back ticks: collision coincides with a tick
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        spaced_ticks(11, 0, 3'd0);

        // Restart coinciding with a tick, mid-run
        cyc(1'b1, 1'b1, 1'b0, 3'd3);
        spaced_ticks(3, 0, 3'd3);
        cyc(1'b1, 1'b1, 1'b1, 3'd3);
        spaced_ticks(2, 0, 3'd3);

        // Player walks onto an occupied bottom cell without a tick
        cyc(1'b1, 1'b1, 1'b0, 3'd2);
        spaced_ticks(8, 1, 3'd2);
        cyc(1'b1, 1'b0, 1'b0, 3'd2);
        cyc(1'b1, 1'b0, 1'b0, 3'd1);
        cyc(1'b1, 1'b0, 1'b0, 3'd1);

        // Long off-field run with a reset pulse in the middle
        cyc(1'b1, 1'b1, 1'b0, 3'd7);
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                cyc(1'b0, 1'b0, 1'b1, 3'd7);
                cyc(1'b0, 1'b0, 1'b0, 3'd7);
                cyc(1'b1, 1'b0, 1'b1, 3'd7);
                cyc(1'b1, 1'b1, 1'b0, 3'd7);
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) cyc(1'b1, 1'b0, 1'b0, 3'd7);
            cyc(1'b1, 1'b0, 1'b1, 3'd7);
        end

        // Random play: moving player, random ticks and restarts
        for (int i = 0; i < 600; i++) begin
            cyc(1'b1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                3'($urandom_range(0, 7)));
        end

        cyc(1'b1, 1'b0, 1'b0, 3'd7);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
